full_subtractor: RTL and testbench

//  Ripple-borrow full subtractor computing {borrow, difference} = a - b - c.

---
 rtl/full_subtractor.sv | 79 +++++++
 tb/tb_full_subtractor.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/full_subtractor.sv
// Ripple-borrow subtractor {borrow, difference} = a - b - c, built only from 2-input NAND gates.
// An optional output register stage (REG_OUT=1) adds one cycle of latency with async active-low clear.
module full_subtractor #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] difference,
    output logic             borrow
);

    logic [WIDTH:0]   borrow_chain;
    logic [WIDTH-1:0] diff_comb;

    assign borrow_chain[0] = c;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic n1, t1, t2, x, b1;
            logic n2, t3, t4, b2;
            logic nb1, nb2;

            // First half subtractor: x = ai ^ bi, b1 = ~ai & bi (t2 doubles as the borrow term p)
            nand u_hs1_n1 (n1, a[gi], b[gi]);
            nand u_hs1_t1 (t1, a[gi], n1);
            nand u_hs1_t2 (t2, b[gi], n1);
            nand u_hs1_x  (x,  t1, t2);
            nand u_hs1_b1 (b1, t2, t2);

            // Second half subtractor against the incoming borrow
            nand u_hs2_n2 (n2, x, borrow_chain[gi]);
            nand u_hs2_t3 (t3, x, n2);
            nand u_hs2_t4 (t4, borrow_chain[gi], n2);
            nand u_hs2_d  (diff_comb[gi], t3, t4);
            nand u_hs2_b2 (b2, t4, t4);

            // OR of both partial borrows, in NAND form
            nand u_or_i1 (nb1, b1, b1);
            nand u_or_i2 (nb2, b2, b2);
            nand u_or_o  (borrow_chain[gi+1], nb1, nb2);
        end

        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] diff_d, diff_q;
            logic             borrow_d, borrow_q;

            always_comb begin
                diff_d   = diff_comb;
                borrow_d = borrow_chain[WIDTH];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    diff_q   <= '0;
                    borrow_q <= 1'b0;
                end else begin
                    diff_q   <= diff_d;
                    borrow_q <= borrow_d;
                end
            end

            assign difference = diff_q;
            assign borrow     = borrow_q;
        end else begin : g_comb
            // Clock and reset have no role in the purely combinational build
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst_n};

            assign difference = diff_comb;
            assign borrow     = borrow_chain[WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_full_subtractor.sv
// Bench for full_subtractor: 1-bit and 4-bit combinational builds plus a 4-bit registered build.
// Expected results come from an integer reference model and flow through a scoreboard queue.
module tb_full_subtractor;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       n_cmp = 0;
    int       n_bad = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:0] a1, b1;
    logic       c1;
    logic [0:0] d1;
    logic       bo1;
    logic [3:0] a4, b4, ar, br;
    logic       c4, cr;
    logic [3:0] d4, dr;
    logic       bo4, bor;

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1), .REG_OUT(1'b0)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .difference(d1), .borrow(bo1)
    );
    full_subtractor #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c(c4), .difference(d4), .borrow(bo4)
    );
    full_subtractor #(.WIDTH(4), .REG_OUT(1'b1)) u_r4 (
        .clk(clk), .rst_n(rst_n), .a(ar), .b(br), .c(cr), .difference(dr), .borrow(bor)
    );

    task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // Reference model: a 5-bit subtraction whose bit 4 is the borrow (sign of a-b-c)
    function automatic logic [4:0] model4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] r;
        r = {1'b0, a} - {1'b0, b} - {4'b0, c};
        return r;
    endfunction

    function automatic logic [4:0] model1(input logic a, input logic b, input logic c);
        logic [1:0] r;
        r = {1'b0, a} - {1'b0, b} - {1'b0, c};
        return {3'b0, r};
    endfunction

    task automatic pop_check(input logic [4:0] got);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", got, 5'h1F ^ got);
        end else begin
            it = sb_q.pop_front();
            check_val(it.tag, got, it.exp);
        end
    endtask

    task automatic run_w1(input logic [2:0] abc);
        {a1, b1, c1} = abc;
        sb_q.push_back('{$sformatf("w1 abc=%b", abc), model1(abc[2], abc[1], abc[0])});
        #5;
        pop_check({3'b0, bo1, d1});
    endtask

    task automatic run_w4(input logic [3:0] a, input logic [3:0] b, input logic c);
        a4 = a; b4 = b; c4 = c;
        sb_q.push_back('{$sformatf("w4 %h-%h-%b", a, b, c), model4(a, b, c)});
        #5;
        pop_check({bo4, d4});
    endtask

    // Drive on the falling edge, compare one rising edge later
    task automatic run_reg(input logic [3:0] a, input logic [3:0] b, input logic c);
        @(negedge clk);
        ar = a; br = b; cr = c;
        sb_q.push_back('{$sformatf("reg %h-%h-%b", a, b, c), model4(a, b, c)});
        @(posedge clk);
        #1;
        pop_check({bor, dr});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        a1 = '0; b1 = '0; c1 = 1'b0;
        a4 = '0; b4 = '0; c4 = 1'b0;
        ar = 4'h0; br = 4'h5; cr = 1'b1;

        // Registered build stays cleared across edges while reset is held
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            ar = 4'($urandom); br = 4'($urandom); cr = 1'($urandom);
            check_val($sformatf("reg_hold_reset_%0d", i), {bor, dr}, 5'h00);
        end

        // All eight 1-bit combinations
        for (int i = 0; i < 8; i++) run_w1(3'(i));

        // 4-bit directed cases including full ripple wrap
        run_w4(4'h3, 4'h5, 1'b0);
        run_w4(4'h9, 4'h2, 1'b1);
        run_w4(4'h0, 4'h0, 1'b1);
        run_w4(4'hF, 4'hF, 1'b0);
        run_w4(4'hF, 4'h0, 1'b1);
        for (int i = 0; i < 12; i++) run_w4(4'($urandom), 4'($urandom), 1'($urandom));

        // Release reset and check one-cycle latency
        @(negedge clk);
        rst_n = 1'b1;
        run_reg(4'h1, 4'h0, 1'b0);
        run_reg(4'h0, 4'h0, 1'b1);
        for (int i = 0; i < 8; i++) run_reg(4'($urandom), 4'($urandom), 1'($urandom));
        run_reg(4'h0, 4'h1, 1'b0);

        // Asynchronous clear between edges
        #2;
        rst_n = 1'b0;
        #1;
        check_val("reg_async_clear", {bor, dr}, 5'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run_reg(4'h7, 4'h3, 1'b1);

        if (sb_q.size() != 0) check_val("scoreboard_leftover", 5'(sb_q.size()), 5'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
